video_pixel_pack: RTL and testbench

//  Inverse of the capture-side pixel demux: packs a stream of pixels at 1/2/4/8/16 bpp

---
 rtl/video_pixel_pack.sv | 115 +++++++++++
 tb/tb_video_pixel_pack.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/video_pixel_pack.sv
// Packs 1/2/4/8/16 bpp pixels into 32-bit little-endian words (pixel 0 at the LSBs)
// with valid/ready handshakes on both the pixel and the word side.
module video_pixel_pack (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  cfg_bpp,
   input  logic [15:0] in_pixel,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_word,
   output logic [5:0]  out_count,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready
);

   logic [31:0] acc_q,       acc_d;
   logic [5:0]  cnt_q,       cnt_d;
   logic [2:0]  bpp_q,       bpp_d;
   logic [31:0] out_word_q,  out_word_d;
   logic [5:0]  out_count_q, out_count_d;
   logic        out_last_q,  out_last_d;
   logic        out_valid_q, out_valid_d;

   logic [2:0]  cfg_code;
   logic [2:0]  bpp_cur;
   logic [4:0]  pix_width;
   logic [5:0]  ppw;
   logic [15:0] pix_masked;
   logic [4:0]  bit_pos;
   logic [5:0]  cnt_inc;
   logic [31:0] merged;
   logic        accept;
   logic        close;

   // Codes above 16bpp are folded onto 16bpp; a word in progress keeps its latched width.
   assign cfg_code  = (cfg_bpp > 3'd4) ? 3'd4 : cfg_bpp;
   assign bpp_cur   = (cnt_q == 6'd0) ? cfg_code : bpp_q;
   assign pix_width = 5'd1 << bpp_cur;
   assign ppw       = 6'd32 >> bpp_cur;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_pix_mask
         assign pix_masked[gi] = in_pixel[gi] & (5'(gi) < pix_width);
      end
   endgenerate

   // cnt*bpp never exceeds 31, so a 5-bit shift amount is exact.
   assign bit_pos = cnt_q[4:0] << bpp_cur;
   assign cnt_inc = cnt_q + 6'd1;
   assign merged  = acc_q | ({16'b0, pix_masked} << bit_pos);

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign close    = accept && ((cnt_inc == ppw) || in_last);

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      bpp_d       = bpp_q;
      out_word_d  = out_word_q;
      out_count_d = out_count_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      if (accept) begin
         bpp_d = bpp_cur;
         if (close) begin
            acc_d = 32'd0;
            cnt_d = 6'd0;
         end else begin
            acc_d = merged;
            cnt_d = cnt_inc;
         end
      end

      // A close may coincide with draining the previous word: reload without a bubble.
      if (close) begin
         out_word_d  = merged;
         out_count_d = cnt_inc;
         out_last_d  = in_last;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q       <= 32'd0;
         cnt_q       <= 6'd0;
         bpp_q       <= 3'd3;
         out_word_q  <= 32'd0;
         out_count_q <= 6'd0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         bpp_q       <= bpp_d;
         out_word_q  <= out_word_d;
         out_count_q <= out_count_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_word  = out_word_q;
   assign out_count = out_count_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_video_pixel_pack.sv
// Bench for video_pixel_pack: directed scenarios plus randomized traffic, all checked
// against a word-level reference model that builds expected words from pixel lists.
module tb_video_pixel_pack;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  cfg_bpp;
   logic [15:0] in_pixel;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_word;
   logic [5:0]  out_count;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   video_pixel_pack dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cfg_bpp   (cfg_bpp),
      .in_pixel  (in_pixel),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_word  (out_word),
      .out_count (out_count),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      int          count;
      logic        last;
   } word_t;

   int     checks   = 0;
   int     failures = 0;
   word_t  exp_q[$];
   int     pix_list[$];
   int     m_bpp = 8;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, want);
      end
   endtask

   // Expected word from the pixel list: pixel n lands at bit n*bpp.
   function automatic logic [31:0] build_word(input int bpp);
      longint w = 0;
      for (int n = 0; n < pix_list.size(); n++)
         w = w + (longint'(pix_list[n]) * (longint'(1) << (n * bpp)));
      return w[31:0];
   endfunction

   task automatic model_eval();
      word_t e;
      int    bpp;
      chk("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0) || out_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (out_valid && out_ready && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("word", out_word, e.word);
         chk("count", {26'b0, out_count}, 32'(e.count));
         chk("last", {31'b0, out_last}, {31'b0, e.last});
      end
      if (in_valid && in_ready) begin
         if (pix_list.size() == 0)
            m_bpp = (cfg_bpp >= 3'd4) ? 16 : (1 << cfg_bpp);
         bpp = m_bpp;
         pix_list.push_back(int'(in_pixel) % (1 << bpp));
         if (pix_list.size() == 32 / bpp || in_last) begin
            e.word  = build_word(bpp);
            e.count = pix_list.size();
            e.last  = in_last;
            exp_q.push_back(e);
            pix_list.delete();
         end
      end
   endtask

   task automatic step(input logic v, input logic [15:0] p, input logic l,
                       input logic [2:0] c, input logic r);
      in_valid  = v;
      in_pixel  = p;
      in_last   = l;
      cfg_bpp   = c;
      out_ready = r;
      @(negedge clk);
      model_eval();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset_n   = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      pix_list.delete();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_word", out_word, 32'd0);
      chk("rst_count", {26'b0, out_count}, 32'd0);
      chk("rst_last", {31'b0, out_last}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic send8(input logic [31:0] w);
      for (int i = 0; i < 4; i++) step(1'b1, {8'h00, w[8*i +: 8]}, 1'b0, 3'd3, 1'b1);
   endtask

   initial begin
      reset_n = 1'b1; cfg_bpp = 3'd3; in_pixel = '0; in_valid = 1'b0;
      in_last = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // 8bpp four pixels
      send8(32'h44332211);
      chk("t1_word", out_word, 32'h44332211);
      chk("t1_count", {26'b0, out_count}, 32'd4);
      chk("t1_last", {31'b0, out_last}, 32'd0);
      step(1'b0, 16'h0, 1'b0, 3'd3, 1'b1);

      // 1bpp alternating, then a 33rd pixel closed by last
      for (int i = 0; i < 32; i++) step(1'b1, 16'((i + 1) % 2) | 16'hFFFE, 1'b0, 3'd0, 1'b1);
      chk("t2_word", out_word, 32'h55555555);
      chk("t2_count", {26'b0, out_count}, 32'd32);
      step(1'b1, 16'h0001, 1'b1, 3'd0, 1'b1);
      chk("t2_new_word", out_word, 32'h00000001);
      chk("t2_new_count", {26'b0, out_count}, 32'd1);
      step(1'b0, 16'h0, 1'b0, 3'd0, 1'b1);

      // 4bpp partial line
      step(1'b1, 16'hFFFA, 1'b0, 3'd2, 1'b1);
      step(1'b1, 16'h000B, 1'b0, 3'd2, 1'b1);
      step(1'b1, 16'h123C, 1'b1, 3'd2, 1'b1);
      chk("t3_word", out_word, 32'h00000CBA);
      chk("t3_count", {26'b0, out_count}, 32'd3);
      chk("t3_last", {31'b0, out_last}, 32'd1);
      step(1'b0, 16'h0, 1'b0, 3'd2, 1'b1);

      // back-pressure: pending word blocks input, then drain+accept together
      send8(32'hDDCCBBAA);
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0055, 1'b0, 3'd3, 1'b0);
      chk("t4_hold_word", out_word, 32'hDDCCBBAA);
      step(1'b1, 16'h0055, 1'b0, 3'd3, 1'b1);
      step(1'b1, 16'h0066, 1'b0, 3'd3, 1'b1);
      step(1'b1, 16'h0077, 1'b0, 3'd3, 1'b1);
      step(1'b1, 16'h0088, 1'b0, 3'd3, 1'b1);
      chk("t4_next_word", out_word, 32'h88776655);
      step(1'b0, 16'h0, 1'b0, 3'd3, 1'b1);

      // bpp latched at word start, cfg change mid-word ignored
      step(1'b1, 16'h1234, 1'b0, 3'd4, 1'b1);
      step(1'b1, 16'h5678, 1'b0, 3'd3, 1'b1);
      chk("t5_word", out_word, 32'h56781234);
      chk("t5_count", {26'b0, out_count}, 32'd2);
      step(1'b0, 16'h0, 1'b0, 3'd3, 1'b1);

      // reset mid-word, then reset with a word pending
      step(1'b1, 16'h00EE, 1'b0, 3'd3, 1'b1);
      step(1'b1, 16'h00FF, 1'b0, 3'd3, 1'b1);
      do_reset();
      send8(32'h04030201);
      chk("t6_word", out_word, 32'h04030201);
      step(1'b0, 16'h0, 1'b0, 3'd3, 1'b0);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 19) == 0),
              3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 3'd3, 1'b1);
      chk("drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
